key_rshift_sched: RTL and testbench

KEY_RSHIFT_SCHED -- requirements
Module: key_rshift_sched

---
 rtl/des_key_pkg.sv | 22 ++
 rtl/cd_rotate.sv | 20 ++
 rtl/key_rshift_sched.sv | 135 +++++++++++++
 tb/tb_key_rshift_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
// Shared types and constants for the DES key schedule.
package des_key_pkg;

  localparam int unsigned CD_W  = 28;
  localparam int unsigned KEY_W = 56;

  typedef enum logic [1:0] {StIdle, StEmit, StFin} sched_state_e;

  // Per-round rotate amount, index = DES round number.
  localparam logic [16:1][1:0] SHIFT_TABLE = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  function automatic logic shift_is_two(input logic [4:0] r);
    if (r >= 5'd1 && r <= 5'd16) begin
      return SHIFT_TABLE[r] == 2'd2;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/cd_rotate.sv
// 28-bit rotate of one key half by 1 or 2 positions, left or right.
module cd_rotate
  import des_key_pkg::*;
(
  input  logic [CD_W-1:0] x,
  input  logic            two,
  input  logic            left,
  output logic [CD_W-1:0] y
);

  always_comb begin
    unique case ({left, two})
      2'b00:   y = {x[0], x[CD_W-1:1]};
      2'b01:   y = {x[1:0], x[CD_W-1:2]};
      2'b10:   y = {x[CD_W-2:0], x[CD_W-1]};
      default: y = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
    endcase
  end

endmodule

// File: rtl/key_rshift_sched.sv
// DES key schedule emitting 16 pre-PC2 subkeys over a valid/ready handshake.
// Optional encrypt (increasing-round) order is enabled by defining KEY_SCHED_ENC_EN.
module key_rshift_sched
  import des_key_pkg::*;
#(
  parameter int unsigned NROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] kin,
  input  logic             mode,
  output logic [KEY_W-1:0] subkey,
  output logic [4:0]       round,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LastCnt = 5'(NROUNDS - 1);

  sched_state_e    state_q, state_d;
  logic [CD_W-1:0] c_q, c_d, d_q, d_d;
  logic [4:0]      round_q, round_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            enc_q, enc_d;
  logic            enc_start;
  logic            xfer;
  logic            idle;
  logic [CD_W-1:0] c_in, d_in, c_rot, d_rot;
  logic            rot_two, rot_left;

`ifdef KEY_SCHED_ENC_EN
  assign enc_start = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign enc_start   = 1'b0;
`endif

  assign idle = (state_q == StIdle);
  assign xfer = sk_valid && sk_ready;

  // In idle the rotators pre-rotate kin left by one for the encrypt-order first subkey.
  assign c_in     = idle ? kin[KEY_W-1:CD_W] : c_q;
  assign d_in     = idle ? kin[CD_W-1:0] : d_q;
  assign rot_left = idle ? 1'b1 : enc_q;
  assign rot_two  = idle ? 1'b0 :
                    (enc_q ? shift_is_two(round_q + 5'd1) : shift_is_two(round_q));

  cd_rotate u_rot_c (
    .x    (c_in),
    .two  (rot_two),
    .left (rot_left),
    .y    (c_rot)
  );

  cd_rotate u_rot_d (
    .x    (d_in),
    .two  (rot_two),
    .left (rot_left),
    .y    (d_rot)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StEmit;
          cnt_d   = 5'd0;
          enc_d   = enc_start;
          if (enc_start) begin
            c_d     = c_rot;
            d_d     = d_rot;
            round_d = 5'd1;
          end else begin
            c_d     = kin[KEY_W-1:CD_W];
            d_d     = kin[CD_W-1:0];
            round_d = 5'(NROUNDS);
          end
        end
      end
      StEmit: begin
        if (xfer) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LastCnt) begin
            state_d = StFin;
            round_d = 5'd0;
          end else begin
            c_d     = c_rot;
            d_d     = d_rot;
            round_d = enc_q ? round_q + 5'd1 : round_q - 5'd1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
    end
  end

  assign subkey   = {c_q, d_q};
  assign round    = round_q;
  assign sk_valid = (state_q == StEmit);
  assign busy     = (state_q == StEmit);
  assign done     = (state_q == StFin);

endmodule

// File: tb/tb_key_rshift_sched.sv
// Self-checking bench for key_rshift_sched against a cumulative-shift key model.
module tb_key_rshift_sched;

  logic        clk = 1'b0;
  logic        rst, start, mode, sk_ready;
  logic [55:0] kin, subkey;
  logic [4:0]  round;
  logic        sk_valid, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_rshift_sched #(.NROUNDS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kin      (kin),
    .mode     (mode),
    .subkey   (subkey),
    .round    (round),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .busy     (busy),
    .done     (done)
  );

  function automatic int shift_of(input int r);
    return (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
  endfunction

  function automatic logic [27:0] rotl_n(input logic [27:0] x, input int n);
    logic [27:0] v = x;
    for (int i = 0; i < n; i++) v = {v[26:0], v[27]};
    return v;
  endfunction

  // Round-r subkey: each half of kin rotated left by the sum of shifts for rounds 1..r.
  function automatic logic [55:0] model_key(input logic [55:0] k, input int r);
    int s = 0;
    for (int i = 1; i <= r; i++) s += shift_of(i);
    return {rotl_n(k[55:28], s), rotl_n(k[27:0], s)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pat: 0 = ready always high, 1 = ready toggles starting low, 2 = random ready.
  task automatic run_sched(input logic [55:0] key, input logic enc, input logic mode_val,
                           input int pat, input bit fin_start, output int cycles);
    int          idx;
    int          exp_r;
    logic        rdy;
    logic [55:0] exp_k;
    kin   = key;
    mode  = mode_val;
    start = 1'b1;
    tick();
    start  = 1'b0;
    idx    = 0;
    cycles = 0;
    while (idx < 16 && cycles < 100) begin
      exp_r = enc ? idx + 1 : 16 - idx;
      exp_k = model_key(key, exp_r);
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = cycles[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sk_ready = rdy;
      tests++;
      if (sk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL emit_flags cyc %0d: valid/busy/done=%b%b%b required 110",
                 cycles, sk_valid, busy, done);
      end
      tests++;
      if (round !== 5'(exp_r)) begin
        fails++;
        $display("FAIL round cyc %0d: got %0d required %0d", cycles, round, exp_r);
      end
      tests++;
      if (subkey !== exp_k) begin
        fails++;
        $display("FAIL subkey round %0d: got %h required %h", exp_r, subkey, exp_k);
      end
      tick();
      cycles++;
      if (rdy) idx++;
    end
    sk_ready = 1'b0;
    tests++;
    if (idx != 16) begin
      fails++;
      $display("FAIL timeout: %0d transfers, required 16", idx);
    end
    tests++;
    if (sk_valid !== 1'b0 || round !== 5'd0 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fin: valid=%b round=%0d done=%b busy=%b required 0 0 1 0",
               sk_valid, round, done, busy);
    end
    if (fin_start) start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (done !== 1'b0 || sk_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_fin: done=%b valid=%b busy=%b required 0 0 0", done, sk_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; sk_ready = 1'b1; kin = {$urandom, $urandom};
    tick();
    tick();
    tests++;
    if (subkey !== 56'd0 || round !== 5'd0 || sk_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      fails++;
      $display("FAIL reset: subkey=%h round=%0d valid=%b busy=%b done=%b required all 0",
               subkey, round, sk_valid, busy, done);
    end
    rst = 1'b0; start = 1'b0; sk_ready = 1'b0;
    tick();
    tests++;
    if (sk_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_prio: valid=%b required 0", sk_valid);
    end
  endtask

  task automatic test_known_vector;
    int n = 0;
    kin = 56'hF0CCAAF556678F; mode = 1'b0; sk_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (round !== 5'd16 || subkey !== 56'hF0CCAAF556678F) begin
      fails++;
      $display("FAIL kv_r16: round=%0d subkey=%h required 16 f0ccaaf556678f", round, subkey);
    end
    tick();
    tests++;
    if (round !== 5'd15 || subkey !== 56'hF866557AAB33C7) begin
      fails++;
      $display("FAIL kv_r15: round=%0d subkey=%h required 15 f866557aab33c7", round, subkey);
    end
    while (round !== 5'd1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (round !== 5'd1 || subkey !== 56'hE19955FAACCF1E) begin
      fails++;
      $display("FAIL kv_r1: round=%0d subkey=%h required 1 e19955faaccf1e", round, subkey);
    end
    tick();
    tests++;
    if (done !== 1'b1 || sk_valid !== 1'b0) begin
      fails++;
      $display("FAIL kv_done: done=%b valid=%b required 1 0", done, sk_valid);
    end
    sk_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_sched(56'hF0CCAAF556678F, 1'b0, 1'b0, 0, 1'b1, cyc);
    tests++;
    if (cyc != 16) begin
      fails++;
      $display("FAIL b2b_cycles: got %0d required 16", cyc);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    run_sched(56'h00000000000001, 1'b0, 1'b0, 1, 1'b0, cyc);
    tests++;
    if (cyc != 32) begin
      fails++;
      $display("FAIL bp_cycles: got %0d required 32", cyc);
    end
  endtask

  task automatic test_random;
    int cyc;
    for (int i = 0; i < 6; i++) begin
`ifdef KEY_SCHED_ENC_EN
      logic m = 1'($urandom_range(0, 1));
      run_sched({$urandom, $urandom}, m, m, 2, 1'($urandom_range(0, 1)), cyc);
`else
      // mode has no effect in this build
      run_sched({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 2,
                1'($urandom_range(0, 1)), cyc);
`endif
    end
  endtask

  task automatic test_abort;
    logic [55:0] key = {$urandom, $urandom};
    int          idx = 0;
    bit          aborted = 1'b0;
    kin = key; mode = 1'b0; sk_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    while (idx < 16 && !aborted) begin
      tests++;
      if (round !== 5'(16 - idx) || subkey !== model_key(key, 16 - idx)) begin
        fails++;
        $display("FAIL abort_run idx %0d: round=%0d subkey=%h required %0d %h",
                 idx, round, subkey, 16 - idx, model_key(key, 16 - idx));
      end
      start = (idx == 3);
      if (round === 5'd9) begin
        rst = 1'b1;
        aborted = 1'b1;
      end
      tick();
      idx++;
    end
    start = 1'b0;
    tests++;
    if (!aborted || subkey !== 56'd0 || round !== 5'd0 || sk_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort: reached=%b subkey=%h round=%0d valid=%b busy=%b done=%b",
               aborted, subkey, round, sk_valid, busy, done);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (done !== 1'b0 || sk_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_nodone: done=%b valid=%b required 0 0", done, sk_valid);
    end
    sk_ready = 1'b0;
  endtask

`ifdef KEY_SCHED_ENC_EN
  task automatic test_enc;
    int cyc;
    kin = 56'hF0CCAAF556678F; mode = 1'b1; sk_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (round !== 5'd1 || subkey !== 56'hE19955FAACCF1E) begin
      fails++;
      $display("FAIL enc_r1: round=%0d subkey=%h required 1 e19955faaccf1e", round, subkey);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_sched(56'hF0CCAAF556678F, 1'b1, 1'b1, 0, 1'b0, cyc);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; sk_ready = 1'b0; kin = '0;
    tick();
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_random();
`ifdef KEY_SCHED_ENC_EN
    test_enc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
